axis_upsizer: RTL and testbench

- AXI4-Stream narrow-to-wide width converter. Default packs 8-bit input beats into 64-bit output words.
- Complements the existing wide-to-narrow axis_adapter path; sits on the receive side ahead of 64-bit datapath logic.
- Little-endian lane packing: first accepted segment goes to output lane 0.
- A word is emitted when all lanes are filled or when tlast arrives, whichever comes first.

---
 rtl/axis_pkg.sv | 17 +
 rtl/axis_upsizer_if.sv | 40 ++++
 rtl/axis_upsizer.sv | 104 ++++++++++
 tb/tb_axis_upsizer.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// rtl/axis_pkg.sv - shared constants, state enum and helpers for the axis upsizer
package axis_pkg;

  localparam int IN_W_DEF    = 8;
  localparam int SEG         = 8;
  localparam int FRAME_CNT_W = 16;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  function automatic int seg_of(input int out_w, input int in_w);
    return out_w / in_w;
  endfunction

endpackage

// File: rtl/axis_upsizer_if.sv
// rtl/axis_upsizer_if.sv - narrow input stream plus wide output stream bundle
interface axis_upsizer_if
  import axis_pkg::*;
#(
  parameter int INPUT_DATA_WIDTH  = IN_W_DEF,
  parameter int INPUT_KEEP_WIDTH  = INPUT_DATA_WIDTH / 8,
  parameter int OUTPUT_DATA_WIDTH = IN_W_DEF * SEG,
  parameter int OUTPUT_KEEP_WIDTH = OUTPUT_DATA_WIDTH / 8
);

  logic [INPUT_DATA_WIDTH-1:0]  input_axis_tdata;
  logic [INPUT_KEEP_WIDTH-1:0]  input_axis_tkeep;
  logic                         input_axis_tvalid;
  logic                         input_axis_tready;
  logic                         input_axis_tlast;
  logic                         input_axis_tuser;

  logic [OUTPUT_DATA_WIDTH-1:0] output_axis_tdata;
  logic [OUTPUT_KEEP_WIDTH-1:0] output_axis_tkeep;
  logic                         output_axis_tvalid;
  logic                         output_axis_tready;
  logic                         output_axis_tlast;
  logic                         output_axis_tuser;

  // slave: the converter's view
  modport slave (
    input  input_axis_tdata, input_axis_tkeep, input_axis_tvalid,
    input  input_axis_tlast, input_axis_tuser, output_axis_tready,
    output input_axis_tready, output_axis_tdata, output_axis_tkeep,
    output output_axis_tvalid, output_axis_tlast, output_axis_tuser
  );

  modport master (
    output input_axis_tdata, input_axis_tkeep, input_axis_tvalid,
    output input_axis_tlast, input_axis_tuser, output_axis_tready,
    input  input_axis_tready, output_axis_tdata, output_axis_tkeep,
    input  output_axis_tvalid, output_axis_tlast, output_axis_tuser
  );

endinterface

// File: rtl/axis_upsizer.sv
// rtl/axis_upsizer.sv - narrow-to-wide AXI-Stream packer, little-endian lanes
// Optional frame counter output enabled by AXIS_UPSIZER_FRAME_CNT_EN.
module axis_upsizer
  import axis_pkg::*;
#(
  parameter int INPUT_DATA_WIDTH  = IN_W_DEF,
  parameter int INPUT_KEEP_WIDTH  = INPUT_DATA_WIDTH / 8,
  parameter int OUTPUT_DATA_WIDTH = IN_W_DEF * SEG,
  parameter int OUTPUT_KEEP_WIDTH = OUTPUT_DATA_WIDTH / 8
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef AXIS_UPSIZER_FRAME_CNT_EN
  output logic [FRAME_CNT_W-1:0] frame_count,
`endif
  axis_upsizer_if.slave          bus
);

  localparam int SEGS = seg_of(OUTPUT_DATA_WIDTH, INPUT_DATA_WIDTH);
  localparam int CW   = (SEGS > 1) ? $clog2(SEGS) : 1;

  if (OUTPUT_DATA_WIDTH % INPUT_DATA_WIDTH != 0) begin : g_width_check
    $error("OUTPUT_DATA_WIDTH must be a multiple of INPUT_DATA_WIDTH");
  end

  state_t                       state, state_nxt;
  logic [CW-1:0]                seg_cnt, seg_nxt;
  logic [OUTPUT_DATA_WIDTH-1:0] data_r, data_nxt;
  logic [OUTPUT_KEEP_WIDTH-1:0] keep_r, keep_nxt;
  logic                         last_r, last_nxt;
  logic                         user_r, user_nxt;
  logic                         in_fire, out_fire, word_done;

  assign bus.input_axis_tready  = (state == ACCUM) || bus.output_axis_tready;
  assign in_fire   = bus.input_axis_tvalid && bus.input_axis_tready;
  assign out_fire  = (state == HOLD) && bus.output_axis_tready;
  assign word_done = bus.input_axis_tlast || (seg_cnt == CW'(SEGS - 1));

  // Lane demux: a drained word is cleared, so a same-cycle beat lands in a fresh lane 0.
  for (genvar g = 0; g < SEGS; g++) begin : g_lane
    logic lane_we;
    assign lane_we = in_fire && (seg_cnt == CW'(g));
    assign data_nxt[g*INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH] =
      lane_we  ? bus.input_axis_tdata :
      out_fire ? '0 : data_r[g*INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH];
    assign keep_nxt[g*INPUT_KEEP_WIDTH +: INPUT_KEEP_WIDTH] =
      lane_we  ? bus.input_axis_tkeep :
      out_fire ? '0 : keep_r[g*INPUT_KEEP_WIDTH +: INPUT_KEEP_WIDTH];
  end

  always_comb begin
    state_nxt = state;
    seg_nxt   = seg_cnt;
    last_nxt  = out_fire ? 1'b0 : last_r;
    user_nxt  = (out_fire ? 1'b0 : user_r) | (in_fire & bus.input_axis_tuser);
    if (in_fire) begin
      if (word_done) begin
        state_nxt = HOLD;
        seg_nxt   = '0;
        last_nxt  = bus.input_axis_tlast;
      end else begin
        state_nxt = ACCUM;
        seg_nxt   = seg_cnt + CW'(1);
      end
    end else if (out_fire) begin
      state_nxt = ACCUM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ACCUM;
      seg_cnt <= '0;
      data_r  <= '0;
      keep_r  <= '0;
      last_r  <= 1'b0;
      user_r  <= 1'b0;
    end else begin
      state   <= state_nxt;
      seg_cnt <= seg_nxt;
      data_r  <= data_nxt;
      keep_r  <= keep_nxt;
      last_r  <= last_nxt;
      user_r  <= user_nxt;
    end
  end

  assign bus.output_axis_tvalid = (state == HOLD);
  assign bus.output_axis_tdata  = data_r;
  assign bus.output_axis_tkeep  = keep_r;
  assign bus.output_axis_tlast  = last_r;
  assign bus.output_axis_tuser  = user_r;

`ifdef AXIS_UPSIZER_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_count <= '0;
    end else if (out_fire && last_r) begin
      frame_count <= frame_count + FRAME_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_axis_upsizer.sv
// tb/tb_axis_upsizer.sv - directed self-checking bench for axis_upsizer
module tb_axis_upsizer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   ready_low = 0;
  logic [63:0] held;

  always #5 clk = ~clk;

  axis_upsizer_if bus ();

`ifdef AXIS_UPSIZER_FRAME_CNT_EN
  logic [15:0] frame_count;
  axis_upsizer dut (.clk(clk), .rst(rst), .frame_count(frame_count), .bus(bus));
`else
  axis_upsizer dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d, input logic k, input logic l, input logic u);
    bus.input_axis_tdata  = d;
    bus.input_axis_tkeep  = k;
    bus.input_axis_tlast  = l;
    bus.input_axis_tuser  = u;
    bus.input_axis_tvalid = 1'b1;
    tick();
    bus.input_axis_tvalid = 1'b0;
    bus.input_axis_tlast  = 1'b0;
    bus.input_axis_tuser  = 1'b0;
  endtask

  task automatic chk_word(input string tag, input logic [63:0] d, input logic [7:0] k,
                          input logic l, input logic u);
    chk({tag, "_valid"}, 64'(bus.output_axis_tvalid), 64'd1);
    chk({tag, "_data"},  bus.output_axis_tdata, d);
    chk({tag, "_keep"},  64'(bus.output_axis_tkeep), 64'(k));
    chk({tag, "_last"},  64'(bus.output_axis_tlast), 64'(l));
    chk({tag, "_user"},  64'(bus.output_axis_tuser), 64'(u));
  endtask

  initial begin
    bus.input_axis_tdata   = '0;
    bus.input_axis_tkeep   = '0;
    bus.input_axis_tvalid  = 1'b0;
    bus.input_axis_tlast   = 1'b0;
    bus.input_axis_tuser   = 1'b0;
    bus.output_axis_tready = 1'b1;

    tick();
    tick();
    rst = 1'b0;
    chk("rst_valid", 64'(bus.output_axis_tvalid), 64'd0);
    chk("rst_data",  bus.output_axis_tdata, 64'd0);
    chk("rst_keep",  64'(bus.output_axis_tkeep), 64'd0);
    chk("rst_last",  64'(bus.output_axis_tlast), 64'd0);
    chk("rst_user",  64'(bus.output_axis_tuser), 64'd0);
    chk("rst_ready", 64'(bus.input_axis_tready), 64'd1);

    // short frame
    beat(8'hcd, 1'b1, 1'b0, 1'b0);
    beat(8'hab, 1'b1, 1'b0, 1'b0);
    beat(8'hcd, 1'b1, 1'b0, 1'b0);
    beat(8'hab, 1'b1, 1'b0, 1'b0);
    chk("short_pre_valid", 64'(bus.output_axis_tvalid), 64'd0);
    beat(8'hcd, 1'b1, 1'b1, 1'b0);
    chk_word("short", 64'h000000cdabcdabcd, 8'h1F, 1'b1, 1'b0);
    tick();
    chk("short_drain_valid", 64'(bus.output_axis_tvalid), 64'd0);
    chk("short_drain_data",  bus.output_axis_tdata, 64'd0);

    // two full words back to back
    for (int i = 1; i <= 16; i++) begin
      if (bus.input_axis_tready !== 1'b1) ready_low++;
      beat(8'(i), 1'b1, (i == 16), 1'b0);
      if (i == 8) chk_word("full0", 64'h0807060504030201, 8'hFF, 1'b0, 1'b0);
      if (i == 9) chk("full_handoff_valid", 64'(bus.output_axis_tvalid), 64'd0);
    end
    chk_word("full1", 64'h100f0e0d0c0b0a09, 8'hFF, 1'b1, 1'b0);
    chk("full_ready_never_low", 64'(ready_low), 64'd0);
    tick();
    chk("full_drain_valid", 64'(bus.output_axis_tvalid), 64'd0);

    // backpressure
    bus.output_axis_tready = 1'b0;
    for (int i = 0; i < 8; i++) beat(8'(8'h21 + i), 1'b1, 1'b0, 1'b0);
    chk_word("bp_word", 64'h2827262524232221, 8'hFF, 1'b0, 1'b0);
    held = bus.output_axis_tdata;
    bus.input_axis_tdata  = 8'h29;
    bus.input_axis_tkeep  = 1'b1;
    bus.input_axis_tlast  = 1'b1;
    bus.input_axis_tvalid = 1'b1;
    #1;
    chk("bp_ready_low", 64'(bus.input_axis_tready), 64'd0);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_stall_ready", 64'(bus.input_axis_tready), 64'd0);
      chk("bp_stall_valid", 64'(bus.output_axis_tvalid), 64'd1);
      chk("bp_stall_data",  bus.output_axis_tdata, held);
    end
    bus.output_axis_tready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(bus.input_axis_tready), 64'd1);
    tick();
    bus.input_axis_tvalid = 1'b0;
    bus.input_axis_tlast  = 1'b0;
    chk_word("bp_next", 64'h29, 8'h01, 1'b1, 1'b0);
    tick();
    chk("bp_drain_valid", 64'(bus.output_axis_tvalid), 64'd0);

    // error flag, then clean frames including a tkeep=0 beat
    beat(8'h31, 1'b1, 1'b0, 1'b0);
    beat(8'h32, 1'b1, 1'b0, 1'b0);
    beat(8'h33, 1'b1, 1'b0, 1'b1);
    beat(8'h34, 1'b1, 1'b1, 1'b0);
    chk_word("err", 64'h34333231, 8'h0F, 1'b1, 1'b1);
    tick();
    beat(8'h41, 1'b1, 1'b1, 1'b0);
    chk_word("err_next", 64'h41, 8'h01, 1'b1, 1'b0);
    tick();
    beat(8'h51, 1'b1, 1'b0, 1'b0);
    beat(8'h52, 1'b0, 1'b1, 1'b0);
    chk_word("keep0", 64'h5251, 8'h01, 1'b1, 1'b0);
    tick();

    // reset mid-word
    beat(8'h61, 1'b1, 1'b0, 1'b0);
    beat(8'h62, 1'b1, 1'b0, 1'b0);
    beat(8'h63, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_data",  bus.output_axis_tdata, 64'd0);
    chk("midrst_valid", 64'(bus.output_axis_tvalid), 64'd0);
    beat(8'h71, 1'b1, 1'b0, 1'b0);
    beat(8'h72, 1'b1, 1'b1, 1'b0);
    chk_word("midrst_word", 64'h7271, 8'h03, 1'b1, 1'b0);
    tick();

`ifdef AXIS_UPSIZER_FRAME_CNT_EN
    chk("fc_one", 64'(frame_count), 64'd1);
    beat(8'h81, 1'b1, 1'b1, 1'b0);
    tick();
    beat(8'h82, 1'b1, 1'b1, 1'b0);
    tick();
    chk("fc_three", 64'(frame_count), 64'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("fc_reset", 64'(frame_count), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
